// File: rtl/ws281x_bit_encoder_if.sv
// Byte stream into the WS281x encoder.
// A byte moves on every rising clock edge where vld and rdy are both high; the source holds
// data stable while vld is high, and rdy never depends on vld.
interface ws281x_bit_encoder_if;
  logic [7:0] data;
  logic       vld;
  logic       rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/ws281x_bit_encoder.sv
// Single-channel WS281x NRZ serialiser: one-byte prefetch buffer, per-bit high/low phase timer,
// frame-frozen timing and a trailing latch gap.
module ws281x_bit_encoder #(
  parameter int RST_CYCLES    = 4000,
  parameter int BYTES_PER_LED = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 frame_start_i,
  input  logic [7:0]           reg_t0h_time_i,
  input  logic [7:0]           reg_t0l_time_i,
  input  logic [7:0]           reg_t1h_time_i,
  input  logic [7:0]           reg_t1l_time_i,
  input  logic [7:0]           reg_chan_len_i,
  ws281x_bit_encoder_if.slave  data_if,
  output logic                 bit_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           fsm_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        bit_q;

  logic [7:0]  t0h_q, t0l_q, t1h_q, t1l_q;
  logic [9:0]  total_q;
  logic [9:0]  fetched_q;
  logic [9:0]  loaded_q;
  logic        buf_full_q;
  logic [7:0]  buf_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  phase_q;
  logic [15:0] latch_q;

  logic        more;
  logic        phase_done;
  logic        hs;
  logic        rdy;
  logic        load_shift;
  logic        shift_next;
  logic        enter_low;
  logic        enter_latch;
  logic        start_frame;

  assign more        = (loaded_q != total_q);
  assign phase_done  = (phase_q == 8'd0);
  assign hs          = data_if.vld & rdy;
  assign start_frame = (state_q == S_IDLE) & frame_start_i;

  // An empty frame still passes through FETCH for one cycle before the latch gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (frame_start_i) state_d = S_FETCH;
      S_FETCH: begin
        if (!more)           state_d = S_LATCH;
        else if (buf_full_q) state_d = S_HIGH;
      end
      S_HIGH:  if (phase_done) state_d = S_LOW;
      S_LOW: begin
        if (phase_done) begin
          if (bit_cnt_q != 3'd0) state_d = S_HIGH;
          else if (!more)        state_d = S_LATCH;
          else if (buf_full_q)   state_d = S_HIGH;
          else                   state_d = S_FETCH;
        end
      end
      S_LATCH: if (latch_q == 16'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_shift  = 1'b0;
    shift_next  = 1'b0;
    enter_low   = 1'b0;
    enter_latch = 1'b0;
    if (state_q == S_FETCH && more && buf_full_q) load_shift = 1'b1;
    if (state_q == S_LOW && phase_done) begin
      if (bit_cnt_q != 3'd0)        shift_next = 1'b1;
      else if (more && buf_full_q)  load_shift = 1'b1;
    end
    if (state_q == S_HIGH && phase_done) enter_low = 1'b1;
    if (state_d == S_LATCH && state_q != S_LATCH) enter_latch = 1'b1;
  end

  // bit_q follows the next state so the pin is registered yet aligned with HIGH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= (state_d == S_HIGH);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      t0h_q      <= 8'd0;
      t0l_q      <= 8'd0;
      t1h_q      <= 8'd0;
      t1l_q      <= 8'd0;
      total_q    <= 10'd0;
      fetched_q  <= 10'd0;
      loaded_q   <= 10'd0;
      buf_full_q <= 1'b0;
      buf_q      <= 8'd0;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      phase_q    <= 8'd0;
      latch_q    <= 16'd0;
    end else begin
      if (start_frame) begin
        t0h_q      <= reg_t0h_time_i;
        t0l_q      <= reg_t0l_time_i;
        t1h_q      <= reg_t1h_time_i;
        t1l_q      <= reg_t1l_time_i;
        total_q    <= 10'(reg_chan_len_i) * 10'(BYTES_PER_LED);
        fetched_q  <= 10'd0;
        loaded_q   <= 10'd0;
        buf_full_q <= 1'b0;
      end

      // rdy is low whenever the buffer is full, so a handshake never meets a load.
      if (hs) begin
        buf_q      <= data_if.data;
        buf_full_q <= 1'b1;
        fetched_q  <= fetched_q + 10'd1;
      end

      if (load_shift) begin
        shift_q    <= buf_q;
        bit_cnt_q  <= 3'd7;
        buf_full_q <= 1'b0;
        loaded_q   <= loaded_q + 10'd1;
        phase_q    <= buf_q[7] ? t1h_q : t0h_q;
      end else if (shift_next) begin
        shift_q    <= shift_q << 1;
        bit_cnt_q  <= bit_cnt_q - 3'd1;
        phase_q    <= shift_q[6] ? t1h_q : t0h_q;
      end else if (enter_low) begin
        phase_q    <= shift_q[7] ? t1l_q : t0l_q;
      end else if ((state_q == S_HIGH || state_q == S_LOW) && !phase_done) begin
        phase_q    <= phase_q - 8'd1;
      end

      if (enter_latch)
        latch_q <= 16'(RST_CYCLES - 1);
      else if (state_q == S_LATCH && latch_q != 16'd0)
        latch_q <= latch_q - 16'd1;
    end
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_LATCH) && (latch_q == 16'd0);
    rdy         = (state_q != S_IDLE) && !buf_full_q && (fetched_q < total_q);
    data_if.rdy = rdy;
    bit_o       = bit_q;
    fsm_state_o = state_q;
  end

endmodule

// File: tb/tb_ws281x_bit_encoder.sv
// Bench for ws281x_bit_encoder: expected bit phase lengths are queued per accepted byte and a
// negedge monitor measures the high/low runs on the LED line against them.
module tb_ws281x_bit_encoder;
  localparam int RST_CYC = 16;
  localparam int EXP_W   = 26;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, start2;
  logic [7:0] t0h, t0l, t1h, t1l, chan_len;
  logic       bit1, busy1, done1, bit2, busy2, done2;
  logic [2:0] state1, state2;

  ws281x_bit_encoder_if dif ();
  ws281x_bit_encoder_if dif2 ();

  ws281x_bit_encoder #(.RST_CYCLES(RST_CYC), .BYTES_PER_LED(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(frame_start),
    .reg_t0h_time_i(t0h), .reg_t0l_time_i(t0l), .reg_t1h_time_i(t1h), .reg_t1l_time_i(t1l),
    .reg_chan_len_i(chan_len), .data_if(dif.slave),
    .bit_o(bit1), .busy_o(busy1), .done_o(done1), .fsm_state_o(state1)
  );

  ws281x_bit_encoder #(.RST_CYCLES(RST_CYC), .BYTES_PER_LED(4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(start2),
    .reg_t0h_time_i(t0h), .reg_t0l_time_i(t0l), .reg_t1h_time_i(t1h), .reg_t1l_time_i(t1l),
    .reg_chan_len_i(chan_len), .data_if(dif2.slave),
    .bit_o(bit2), .busy_o(busy2), .done_o(done2), .fsm_state_o(state2)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {exact_low, low_len[15:0], high_len[8:0]} for each bit, in wire order
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       byte_src[$];
  int cur_t0h, cur_t0l, cur_t1h, cur_t1l;
  int rise_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min_v);
    checks++;
    if (act < min_v) begin
      failures++;
      $display("FAIL %s: actual=%0d expected>=%0d", name, act, min_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: a byte becomes eight bits MSB first, each with frame-captured timing
  task automatic push_byte(input logic [7:0] d, input bit last_byte, input bit exact_tail);
    for (int b = 7; b >= 0; b--) begin
      int hi;
      int lo;
      bit ex;
      hi = d[b] ? cur_t1h + 1 : cur_t0h + 1;
      lo = d[b] ? cur_t1l + 1 : cur_t0l + 1;
      ex = 1'b1;
      if (b == 0 && last_byte)   lo = lo + RST_CYC;
      if (b == 0 && !exact_tail) ex = 1'b0;
      exp_q.push_back({ex, 16'(lo), 9'(hi)});
    end
  endtask

  // monitor / scoreboard
  int mon_phase = 0;
  int mon_hi    = 0;
  int mon_lo    = 0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst_n) begin
      mon_phase = 0;
      mon_hi    = 0;
      mon_lo    = 0;
    end else begin
      case (mon_phase)
        0: if (bit1) begin
          mon_phase = 1; mon_hi = 1; rise_cnt++;
        end
        1: if (bit1) mon_hi++;
        else begin
          if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
          else begin
            e = exp_q[0];
            check("bit_high_len", mon_hi, int'(e[8:0]));
          end
          mon_phase = 2; mon_lo = 1;
        end
        default: begin
          if (bit1 || done1) begin
            if (!bit1) mon_lo++;
            if (exp_q.size() == 0) check("unexpected_low", 1, 0);
            else begin
              e = exp_q.pop_front();
              if (e[25]) check("bit_low_len", mon_lo, int'(e[24:9]));
              else       check_ge("bit_low_min", mon_lo, int'(e[24:9]));
            end
            if (bit1) begin
              mon_phase = 1; mon_hi = 1; rise_cnt++;
            end else mon_phase = 0;
          end else mon_lo++;
        end
      endcase
    end
  end

  // driver: one frame of len LEDs; optional underflow stall, mid-frame reg change, stray starts
  task automatic run_frame(input int len, input int stall_after, input int stall_len,
                           input bit t1h_bump, input bit pulse_busy, input bit pulse_done);
    int n, guard, extra_acc;
    logic [7:0] d;
    n = len * 3;
    cur_t0h = t0h; cur_t0l = t0l; cur_t1h = t1h; cur_t1l = t1l;
    rise_cnt = 0;
    chan_len = 8'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_start", busy1, 1);
    if (t1h_bump) t1h = t1h + 8'd6;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (stall_after >= 0 && i == stall_after + 1) begin
        guard = 0;
        while (rise_cnt < 8 * (stall_after + 1) && guard < 3000) begin tick(); guard++; end
        repeat (stall_len) tick();
      end
      if (pulse_busy && i == 1) begin
        frame_start = 1'b1; tick(); frame_start = 1'b0;
      end
      d = (byte_src.size() > 0) ? byte_src.pop_front() : 8'($urandom);
      dif.data = d;
      dif.vld  = 1'b1;
      guard = 0;
      while (!dif.rdy && guard < 3000) begin tick(); guard++; end
      if (!dif.rdy) begin
        check("rdy_timeout", 0, 1);
        dif.vld = 1'b0;
        break;
      end
      push_byte(d, i == n - 1, !(i == stall_after));
      tick();
      dif.vld = 1'b0;
      if (i == 0 || (stall_after >= 0 && i == stall_after + 1)) begin
        check("line_low_after_hs", bit1, 0);
        tick();
        check("line_high_2_after_hs", bit1, 1);
      end
    end
    dif.data = 8'($urandom);
    dif.vld  = 1'b1;
    extra_acc = 0;
    guard = 0;
    while (!done1 && guard < 20000) begin
      if (dif.rdy) extra_acc++;
      tick(); guard++;
    end
    check("extra_byte_refused", extra_acc, 0);
    check("done_seen", done1, 1);
    check("busy_in_done_cycle", busy1, 1);
    if (pulse_done) frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    dif.vld = 1'b0;
    check("done_one_cycle", done1, 0);
    check("busy_dropped", busy1, 0);
    if (pulse_done) begin
      tick();
      check("start_at_done_ignored", busy1, 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic run_empty();
    int busy_cnt, rdy_cnt, done_cnt, hi_cnt, guard;
    chan_len = 8'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    busy_cnt = 0; rdy_cnt = 0; done_cnt = 0; hi_cnt = 0; guard = 0;
    dif.vld = 1'b1;
    while (busy1 && guard < 200) begin
      busy_cnt++;
      if (dif.rdy) rdy_cnt++;
      if (done1)   done_cnt++;
      if (bit1)    hi_cnt++;
      tick(); guard++;
    end
    dif.vld = 1'b0;
    check("empty_busy_cycles", busy_cnt, RST_CYC + 1);
    check("empty_no_rdy", rdy_cnt, 0);
    check("empty_done_pulses", done_cnt, 1);
    check("empty_line_low", hi_cnt, 0);
  endtask

  task automatic run_abort();
    int guard, i;
    bit took;
    cur_t0h = t0h; cur_t0l = t0l; cur_t1h = t1h; cur_t1l = t1l;
    rise_cnt = 0;
    chan_len = 8'd2;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    dif.data = 8'($urandom);
    dif.vld  = 1'b1;
    i = 0; guard = 0;
    while (rise_cnt < 9 && guard < 3000) begin
      took = dif.rdy;
      if (took) begin push_byte(dif.data, i == 5, 1'b1); i++; end
      tick(); guard++;
      if (took) dif.data = 8'($urandom);
    end
    check("abort_reached_byte2", rise_cnt, 9);
    rst_n = 1'b0;
    #1;
    check("abort_bit_low", bit1, 0);
    check("abort_busy_low", busy1, 0);
    check("abort_rdy_low", dif.rdy, 0);
    check("abort_done_low", done1, 0);
    check("abort_state_idle", state1, 0);
    exp_q.delete();
    dif.vld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_big();
    int acc, rises, guard;
    logic prev;
    t0h = 8'd0; t0l = 8'd0; t1h = 8'd0; t1l = 8'd0;
    chan_len = 8'd255;
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("big_busy", busy2, 1);
    dif2.vld = 1'b1;
    dif2.data = 8'($urandom);
    acc = 0; rises = 0; guard = 0; prev = 1'b0;
    while (!done2 && guard < 40000) begin
      if (dif2.rdy) acc++;
      start2 = (guard == 100);
      tick(); guard++;
      dif2.data = 8'($urandom);
      if (bit2 && !prev) rises++;
      prev = bit2;
    end
    start2 = 1'b0;
    check("big_done", done2, 1);
    check("big_bytes_accepted", acc, 1020);
    check("big_bits_sent", rises, 8160);
    start2 = 1'b1; tick(); start2 = 1'b0;
    dif2.vld = 1'b0;
    check("big_done_one_cycle", done2, 0);
    check("big_busy_dropped", busy2, 0);
    tick();
    check("big_start_at_done_ignored", busy2, 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; start2 = 1'b0;
    t0h = 8'd1; t0l = 8'd3; t1h = 8'd3; t1l = 8'd1; chan_len = 8'd0;
    dif.data = 8'd0; dif.vld = 1'b0; dif2.data = 8'd0; dif2.vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit", bit1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_rdy", dif.rdy, 0);
    check("rst_state", state1, 0);
    rst_n = 1'b1;
    tick();

    // known pattern with asymmetric '0'/'1' timing
    byte_src = '{8'hA5, 8'h00, 8'hFF};
    run_frame(1, -1, 0, 1'b0, 1'b0, 1'b0);

    run_empty();

    // underflow after the third byte
    run_frame(2, 2, 20, 1'b0, 1'b0, 1'b0);

    // t1h changes mid-frame, then takes effect on the following frame
    t1h = 8'd3;
    run_frame(2, -1, 0, 1'b1, 1'b0, 1'b0);
    run_frame(1, -1, 0, 1'b0, 1'b0, 1'b0);

    t0h = 8'd1; t0l = 8'd3; t1h = 8'd3; t1l = 8'd1;
    run_abort();
    run_frame(1, -1, 0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      t0h = 8'($urandom_range(0, 7));
      t0l = 8'($urandom_range(0, 7));
      t1h = 8'($urandom_range(0, 7));
      t1l = 8'($urandom_range(0, 7));
      run_frame($urandom_range(1, 4), -1, 0, 1'b0, k[0], (k % 3) == 0);
    end

    run_big();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
